// File: rtl/wb_cfg_pkg.sv
// wb_cfg_pkg: shared types and constants for the Wishbone configuration master.
//   - wb_state_e       : FSM state encoding (IDLE, BUS, RESP, GAP)
//   - WB_AW/WB_DW      : Wishbone address / data widths
//   - WB_SELW          : byte-select width
//   - *_DEF            : default values for the master's parameters
//   - max_u()          : helper used to size the shared counter
package wb_cfg_pkg;

  localparam int unsigned WB_AW              = 32;
  localparam int unsigned WB_DW              = 32;
  localparam int unsigned WB_SELW            = 4;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 256;
  localparam int unsigned GAP_CYCLES_DEF     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } wb_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wb_cfg_master.sv
// wb_cfg_master: single-outstanding Wishbone classic master for configuration
// accesses. One request is taken in IDLE, driven on the bus until ACK/ERR or a
// timeout, reported with a one-cycle response pulse, then followed by an
// optional idle gap with CYC_O low.
// Ports:
//   CLK_I, RST_N_I          : clock, synchronous active-low reset
//   req_valid_i/ready_o     : request handshake (ready only in IDLE)
//   req_we_i/adr_i/dat_i    : request direction, address, write data
//   rsp_valid_o             : one-cycle response pulse
//   rsp_dat_o               : read data (held between reads)
//   rsp_err_o/timeout_o     : termination status, qualified by rsp_valid_o
//   busy_o                  : high in every state other than IDLE
//   CYC_O..SEL_O, DAT_I, ACK_I, ERR_I : Wishbone classic master port
module wb_cfg_master
  import wb_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES     = GAP_CYCLES_DEF
) (
  input  logic               CLK_I,
  input  logic               RST_N_I,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [WB_AW-1:0]   req_adr_i,
  input  logic [WB_DW-1:0]   req_dat_i,
  output logic               rsp_valid_o,
  output logic [WB_DW-1:0]   rsp_dat_o,
  output logic               rsp_err_o,
  output logic               rsp_timeout_o,
  output logic               busy_o,
  output logic               CYC_O,
  output logic               STB_O,
  output logic               WE_O,
  output logic [WB_AW-1:0]   ADR_O,
  output logic [WB_DW-1:0]   DAT_O,
  output logic [WB_SELW-1:0] SEL_O,
  input  logic [WB_DW-1:0]   DAT_I,
  input  logic               ACK_I,
  input  logic               ERR_I
);

  // One counter serves as the BUS timeout counter and the GAP counter, so it
  // is wide enough for whichever of the two limits is larger.
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CNT_W = max_u(TO_W, GAP_W);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  wb_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [WB_DW-1:0]   dat_q, dat_d;
  logic [WB_SELW-1:0] sel_q, sel_d;
  logic               ready_q, ready_d, busy_q, busy_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic               rsp_to_q, rsp_to_d;
  logic [WB_DW-1:0]   rsp_dat_q, rsp_dat_d;

  logic accept_s, timeout_hit_s, bus_done_s;

  // ready_q is only ever set while IDLE, so it also blocks the first edge after reset.
  assign accept_s      = (state_q == ST_IDLE) && ready_q && req_valid_i;
  assign timeout_hit_s = (cnt_q == TO_LAST);
  // ACK/ERR are only looked at in BUS; the timeout is the last resort.
  assign bus_done_s    = (state_q == ST_BUS) && (ACK_I || ERR_I || timeout_hit_s);

  // State and all registered outputs.
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= {WB_AW{1'b0}};
      dat_q       <= {WB_DW{1'b0}};
      sel_q       <= {WB_SELW{1'b0}};
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      rsp_dat_q   <= {WB_DW{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_BUS;
        else          state_d = ST_IDLE;
      end
      ST_BUS: begin
        if (bus_done_s) state_d = ST_RESP;
        else            state_d = ST_BUS;
      end
      ST_RESP: begin
        if (GAP_CYCLES > 0) state_d = ST_GAP;
        else                state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                   state_d = ST_GAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the shared counter.
  always_comb begin
    cnt_d       = CNT_ZERO;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_to_d    = 1'b0;
    rsp_dat_d   = rsp_dat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          cyc_d = 1'b1;
          stb_d = 1'b1;
          we_d  = req_we_i;
          adr_d = req_adr_i;
          dat_d = req_dat_i;
          sel_d = {WB_SELW{1'b1}};
        end else begin
          cyc_d = 1'b0;
          stb_d = 1'b0;
        end
      end
      ST_BUS: begin
        if (bus_done_s) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_I;
          // ACK or ERR on the timeout edge still wins over the timeout.
          rsp_to_d    = !ACK_I && !ERR_I;
          if (ACK_I && !ERR_I && !we_q) rsp_dat_d = DAT_I;
          else                          rsp_dat_d = rsp_dat_q;
        end else begin
          // Saturate rather than wrap; termination fires at TO_LAST anyway.
          if (timeout_hit_s) cnt_d = cnt_q;
          else               cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RESP: begin
        cnt_d = CNT_ZERO;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) cnt_d = CNT_ZERO;
        else                   cnt_d = cnt_q + CNT_ONE;
      end
      default: begin
        cnt_d = CNT_ZERO;
      end
    endcase
    // Registered, so both follow the state that is entered at this edge.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  assign req_ready_o   = ready_q;
  assign busy_o        = busy_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_to_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign CYC_O         = cyc_q;
  assign STB_O         = stb_q;
  assign WE_O          = we_q;
  assign ADR_O         = adr_q;
  assign DAT_O         = dat_q;
  assign SEL_O         = sel_q;

endmodule
